// File: rtl/stopwatch_time_counter.sv
// Stopwatch MM:SS.cc BCD counter with lap freeze; define STOPWATCH_SATURATE_EN to hold at max time instead of wrapping.
// Latency: tick or button edge -> time_bcd one clock later; no backpressure, tick and buttons are edge-detected single-cycle events.
module stopwatch_time_counter #(
   parameter int MINUTE_LIMIT = 60
) (
   input  logic        CLK_50_MHz,
   input  logic        reset_n,
   input  logic        CLK_100Hz,
   input  logic        start_stop,
   input  logic        lap_reset,
   output logic [23:0] time_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE, RUN, RUN_LAP, STOP} state_t;

   typedef struct packed {
      logic [3:0] m_tens;
      logic [3:0] m_ones;
      logic [3:0] s_tens;
      logic [3:0] s_ones;
      logic [3:0] cs_tens;
      logic [3:0] cs_ones;
   } bcd_time_t;

   localparam logic [3:0] MAX_M_TENS = 4'((MINUTE_LIMIT - 1) / 10);
   localparam logic [3:0] MAX_M_ONES = 4'((MINUTE_LIMIT - 1) % 10);

   state_t    state, state_nxt;
   bcd_time_t cnt, cnt_nxt, cnt_inc;
   bcd_time_t lap_hold, lap_nxt;
   logic      ovf_nxt;
   logic      tick_prev, ss_prev, lap_prev;
   logic      tick_en, ss_ev, lap_ev, cnt_en;
   logic      c0, c1, c2, c3, min_max, at_max;

   // Prev registers reset high so a level already asserted at reset release is not an edge.
   assign tick_en = CLK_100Hz  & ~tick_prev;
   assign ss_ev   = start_stop & ~ss_prev;
   assign lap_ev  = lap_reset  & ~lap_prev;
   assign cnt_en  = tick_en & ((state == RUN) || (state == RUN_LAP));

   assign running    = (state == RUN) || (state == RUN_LAP);
   assign lap_active = (state == RUN_LAP);

   assign c0      = (cnt.cs_ones == 4'd9);
   assign c1      = c0 && (cnt.cs_tens == 4'd9);
   assign c2      = c1 && (cnt.s_ones == 4'd9);
   assign c3      = c2 && (cnt.s_tens == 4'd5);
   assign min_max = (cnt.m_tens == MAX_M_TENS) && (cnt.m_ones == MAX_M_ONES);
   assign at_max  = c3 && min_max;

   always_comb begin
      cnt_inc         = cnt;
      cnt_inc.cs_ones = c0 ? 4'd0 : cnt.cs_ones + 4'd1;
      if (c0) cnt_inc.cs_tens = c1 ? 4'd0 : cnt.cs_tens + 4'd1;
      if (c1) cnt_inc.s_ones  = c2 ? 4'd0 : cnt.s_ones + 4'd1;
      if (c2) cnt_inc.s_tens  = c3 ? 4'd0 : cnt.s_tens + 4'd1;
      if (c3) begin
         if (min_max) begin
            cnt_inc.m_tens = 4'd0;
            cnt_inc.m_ones = 4'd0;
         end else if (cnt.m_ones == 4'd9) begin
            cnt_inc.m_tens = cnt.m_tens + 4'd1;
            cnt_inc.m_ones = 4'd0;
         end else begin
            cnt_inc.m_ones = cnt.m_ones + 4'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_en ? cnt_inc : cnt;
      lap_nxt   = lap_hold;
      ovf_nxt   = overflow;
      if (cnt_en && at_max) begin
         ovf_nxt = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
         cnt_nxt = cnt;
`endif
      end
      // Counting above uses the current state; start/stop has priority over lap.
      case (state)
         IDLE:    if (ss_ev) state_nxt = RUN;
         RUN: begin
            if (ss_ev) begin
               state_nxt = STOP;
            end else if (lap_ev) begin
               state_nxt = RUN_LAP;
               lap_nxt   = cnt_nxt;
            end
         end
         RUN_LAP: begin
            if (ss_ev)       state_nxt = STOP;
            else if (lap_ev) state_nxt = RUN;
         end
         STOP: begin
            if (ss_ev) begin
               state_nxt = RUN;
            end else if (lap_ev) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               lap_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
`ifdef STOPWATCH_SATURATE_EN
      if (cnt_en && at_max) state_nxt = STOP;
`endif
   end

   always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lap_hold  <= '0;
         overflow  <= 1'b0;
         time_bcd  <= '0;
         tick_prev <= 1'b1;
         ss_prev   <= 1'b1;
         lap_prev  <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lap_hold  <= lap_nxt;
         overflow  <= ovf_nxt;
         time_bcd  <= (state_nxt == RUN_LAP) ? lap_nxt : cnt_nxt;
         tick_prev <= CLK_100Hz;
         ss_prev   <= start_stop;
         lap_prev  <= lap_reset;
      end
   end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter, built with MINUTE_LIMIT = 2 so rollover is reachable.
// Expected values are hand-computed; the saturating variant is selected by STOPWATCH_SATURATE_EN.
module tb_stopwatch_time_counter;

   localparam int ML = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tick_in;
   logic        start_stop;
   logic        lap_reset;
   logic [23:0] time_bcd;
   logic        running;
   logic        lap_active;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   stopwatch_time_counter #(.MINUTE_LIMIT(ML)) dut (
      .CLK_50_MHz (clk),
      .reset_n    (reset_n),
      .CLK_100Hz  (tick_in),
      .start_stop (start_stop),
      .lap_reset  (lap_reset),
      .time_bcd   (time_bcd),
      .running    (running),
      .lap_active (lap_active),
      .overflow   (overflow)
   );

   always #10 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk) tick_in = 1'b1;
         @(negedge clk) tick_in = 1'b0;
      end
      cycles(2);
   endtask

   task automatic press_ss();
      @(negedge clk) start_stop = 1'b1;
      @(negedge clk) start_stop = 1'b0;
      cycles(2);
   endtask

   task automatic press_lap();
      @(negedge clk) lap_reset = 1'b1;
      @(negedge clk) lap_reset = 1'b0;
      cycles(2);
   endtask

   initial begin
      reset_n    = 1'b0;
      tick_in    = 1'b0;
      start_stop = 1'b1;
      lap_reset  = 1'b0;
      cycles(3);
      check("rst_time", time_bcd, 24'h000000);
      check("rst_running", {23'd0, running}, 24'd0);
      check("rst_lap", {23'd0, lap_active}, 24'd0);
      check("rst_ovf", {23'd0, overflow}, 24'd0);

      // start_stop held through reset release must not start the watch
      @(negedge clk) reset_n = 1'b1;
      cycles(4);
      check("held_ss_no_start", {23'd0, running}, 24'd0);
      @(negedge clk) start_stop = 1'b0;
      cycles(2);
      press_lap();
      check("idle_lap_noop", {22'd0, running, lap_active}, 24'd0);
      press_ss();
      check("start_running", {23'd0, running}, 24'd1);

      // lap freeze at 00:00.42, count keeps going underneath
      tick(42);
      check("run_42", time_bcd, 24'h000042);
      press_lap();
      check("lap_active", {23'd0, lap_active}, 24'd1);
      tick(58);
      check("lap_frozen", time_bcd, 24'h000042);
      press_lap();
      check("lap_release", time_bcd, 24'h000100);
      check("lap_release_flag", {22'd0, running, lap_active}, 24'd2);

      // stop, then ticks ignored
      tick(100);
      check("run_200", time_bcd, 24'h000200);
      press_ss();
      check("stop_running", {23'd0, running}, 24'd0);
      tick(5);
      check("stop_hold", time_bcd, 24'h000200);

      // tick coincident with STOP->RUN is not counted
      @(negedge clk) begin start_stop = 1'b1; tick_in = 1'b1; end
      @(negedge clk) begin start_stop = 1'b0; tick_in = 1'b0; end
      cycles(2);
      check("restart_tick_ignored", time_bcd, 24'h000200);
      check("restart_running", {23'd0, running}, 24'd1);

      // tick coincident with RUN->STOP is counted
      tick(7);
      @(negedge clk) begin start_stop = 1'b1; tick_in = 1'b1; end
      @(negedge clk) begin start_stop = 1'b0; tick_in = 1'b0; end
      cycles(2);
      check("stop_tick_counted", time_bcd, 24'h000208);
      check("stop_tick_running", {23'd0, running}, 24'd0);
      tick(3);
      check("stop_tick_after", time_bcd, 24'h000208);

      // start_stop and lap_reset together from RUN: stop only
      press_ss();
      @(negedge clk) begin start_stop = 1'b1; lap_reset = 1'b1; end
      @(negedge clk) begin start_stop = 1'b0; lap_reset = 1'b0; end
      cycles(2);
      check("both_from_run", {22'd0, running, lap_active}, 24'd0);
      check("both_time", time_bcd, 24'h000208);

      // clear from STOP
      press_lap();
      check("clear_time", time_bcd, 24'h000000);

      // RUN_LAP -> STOP unfreezes the display
      press_ss();
      tick(10);
      press_lap();
      tick(5);
      check("lap_frozen_10", time_bcd, 24'h000010);
      press_ss();
      check("lap_stop_live", time_bcd, 24'h000015);
      check("lap_stop_flags", {22'd0, running, lap_active}, 24'd0);
      press_lap();
      check("clear2_time", time_bcd, 24'h000000);

      // run to the maximum, across the minute carry
      press_ss();
      tick(5999);
      check("sec_max", time_bcd, 24'h005999);
      tick(1);
      check("minute_carry", time_bcd, 24'h010000);
      tick(5999);
      check("at_max", time_bcd, 24'h015999);
      check("at_max_ovf", {23'd0, overflow}, 24'd0);
      tick(1);
`ifdef STOPWATCH_SATURATE_EN
      check("sat_time", time_bcd, 24'h015999);
      check("sat_ovf", {23'd0, overflow}, 24'd1);
      check("sat_running", {23'd0, running}, 24'd0);
      tick(3);
      check("sat_hold", time_bcd, 24'h015999);
`else
      check("wrap_time", time_bcd, 24'h000000);
      check("wrap_ovf", {23'd0, overflow}, 24'd1);
      check("wrap_running", {23'd0, running}, 24'd1);
      tick(315);
      check("wrap_315", time_bcd, 24'h000315);
      press_ss();
      check("wrap_stop_ovf", {23'd0, overflow}, 24'd1);
`endif

      // clear from STOP with overflow set
      press_lap();
      check("clear_ovf_time", time_bcd, 24'h000000);
      check("clear_ovf", {23'd0, overflow}, 24'd0);
      check("clear_idle", {22'd0, running, lap_active}, 24'd0);
      press_ss();
      check("restart_after_clear", {23'd0, running}, 24'd1);

      // asynchronous reset mid-run
      tick(3);
      check("pre_reset", time_bcd, 24'h000003);
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("async_rst_time", time_bcd, 24'h000000);
      check("async_rst_running", {23'd0, running}, 24'd0);
      cycles(2);
      @(negedge clk) reset_n = 1'b1;
      cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
